prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Multi-channel programmable clock/tick generator; successor to the fixed power-of-two divider.
- Keeps a free-running counter bus for the legacy power-of-two taps.
- Adds NUM_CH independent channels, each with a runtime ratio, enable, glitch-free ratio update at period boundaries, and a global phase-sync.
- Outputs are clock-enable style signals (div_clk level, tick pulse) for board logic driven from the system clock.

Parameters:
- NUM_CH, 4, number of programmable channels (1..16).
- DIV_W, 26, width of divide ratio per channel.
- CNT_W, 32, width of free-running counter.

Ports:
- clock  in  1  system clock, all logic posedge.
- reset  in  1  asynchronous, active-low reset.
- sync  in  1  restart all enabled channels in phase.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted.
- cfg_chan  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  DIV_W  new divide ratio.
- cfg_en  in  1  new channel enable.
- div_clk  out  NUM_CH  per-channel divided level, registered.
- tick  out  NUM_CH  per-channel one-cycle pulse per period, registered.
- divided_clocks  out  CNT_W  free-running counter; bit k has period 2^(k+1) clocks.

Behaviour:
- Reset (reset=0, async): divided_clocks=0, div_clk=0, tick=0, all channel counters 0, active ratios 0, enables 0, no pending updates. cfg_ready=1 after reset.
- divided_clocks increments by 1 every cycle, wraps at 2^CNT_W-1 -> 0. Not affected by sync or config.
- Per channel i state: cnt (DIV_W), act_div, act_en, pend_div, pend_en, pend_v.
- Handshake: write accepted when cfg_valid && cfg_ready. cfg_ready = !pend_v[cfg_chan] (combinational on cfg_chan). Accepted write sets pend_v, pend_div, pend_en. Out-of-range cfg_chan (>= NUM_CH): cfg_ready=1, write accepted and dropped.
- Pending apply: pend_v is applied on the first cycle strictly after acceptance where either act_en=0, act_div<2, or cnt==act_div-1 (period end).
  - Apply: act_div<=pend_div, act_en<=pend_en, cnt<=0, pend_v<=0.
  - A pending update never truncates or stretches the running period.
- Running (act_en=1, act_div>=2): cnt counts 0..act_div-1, then wraps to 0.
  - tick[i]=1 for exactly the cycle after cnt==act_div-1.
  - div_clk[i]=1 while the registered cnt < ceil(act_div/2).
  - Odd ratio N: high ceil(N/2) cycles, low floor(N/2) cycles.
- act_div==1 with act_en=1: tick[i]=1 every cycle; div_clk[i]=1 constant.
- act_div==0 or act_en=0: channel stopped; cnt=0, div_clk[i]=0, tick[i]=0 from the cycle after the apply.
- First tick after apply at ratio N: N cycles after the apply cycle. First div_clk high: 1 cycle after apply.
- sync=1: every enabled channel sets cnt<=0 the same cycle.
  - Any pend_v on that channel is applied simultaneously, treating sync as a period boundary.
  - div_clk and tick realign to all channels starting high together.
- Simultaneous sync and cfg accept on the same channel: sync uses the state before the write; the new write stays pending.
- Simultaneous period end and cfg accept: the new write applies at the next period end, not this one.
- Reset mid-operation: everything returns to reset values immediately; pending writes are lost.
- Width rule: cnt compare uses act_div-1 computed in DIV_W bits; ratios up to 2^DIV_W-1 are legal.

Decomposition:
- Package prog_clock_divider_pkg: DIV_W/CNT_W defaults, chan_cfg_t struct {div, en}, localparam MIN_RUN_DIV=2.
- One sub-module, clk_div_channel: holds cnt, act/pend registers and output regs for one channel. Instantiated NUM_CH times via generate.
- Top level holds divided_clocks, channel decode and the cfg_ready mux.

Test Plan:
- Reset release, no config: divided_clocks counts 0,1,2…; div_clk=0, tick=0 for 100 cycles; cfg_ready=1.
- Write ch0 div=4 en=1: tick[0] every 4 cycles, first 4 cycles after apply; div_clk[0] pattern 1100 repeating.
- ch1 div=5: div_clk[1] 11100 repeating (3 high, 2 low); tick[1] period 5.
- ch0 running div=4, write div=6 at cnt=1: period stays 4 until the boundary, then 6; second write while pending sees cfg_ready=0 until apply.
- ch0 div=3, ch1 div=7 running, pulse sync: both div_clk rise the cycle after sync; ticks at +3 and +7.
- Assert reset mid-period with a pending write: outputs 0 immediately; after release the channel stays stopped and the pending write is discarded.

Source files
------------

// File: rtl/prog_clock_divider_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_clock_divider_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DIV_W   = 26;
    localparam int DEF_CNT_W   = 32;

    // Smallest ratio that produces a counting period; 1 is a constant tick.
    localparam int MIN_RUN_DIV = 2;

    // One channel configuration word. The ratio field is sized by
    // DEF_DIV_W, so the top-level DIV_W must be left at its default.
    typedef struct packed {
        logic [DEF_DIV_W-1:0] div;
        logic                 en;
    } chan_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One programmable divider channel: counter, active/pending config, outputs.
// Latency: div_clk/tick registered one cycle behind cnt; writes apply at the next period boundary or sync.
// Backpressure: pend_busy stays high from acceptance until the pending write is applied.
//
// Ports: clock, reset (async active-low), sync (phase restart),
//        wr (accepted write strobe for this channel), wr_cfg (ratio/enable),
//        pend_busy (a write is waiting), div_clk (divided level), tick (period pulse).
module clk_div_channel
    import prog_clock_divider_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      sync,
    input  logic      wr,
    input  chan_cfg_t wr_cfg,
    output logic      pend_busy,
    output logic      div_clk,
    output logic      tick
);

    logic [DEF_DIV_W-1:0] cnt;
    logic [DEF_DIV_W-1:0] last;
    logic [DEF_DIV_W-1:0] half;
    chan_cfg_t            act;
    chan_cfg_t            pend;
    logic                 pend_v;
    logic                 counting;
    logic                 at_end;
    logic                 boundary;
    logic                 apply;

    always_comb begin
        // Last count value, computed in DIV_W bits so the maximum ratio works.
        last     = act.div - 1'b1;
        // High phase length is ceil(div/2): odd ratios spend the extra cycle high.
        half     = (act.div >> 1) + DEF_DIV_W'(act.div[0]);
        counting = act.en && (act.div != '0);
        at_end   = (cnt == last);
        // A stopped or sub-minimum channel has no period to protect, so a
        // pending write can land on any cycle.
        boundary = !act.en || (act.div < DEF_DIV_W'(MIN_RUN_DIV)) || at_end;
        // pend_v is registered, so a write accepted this cycle cannot apply
        // until a later cycle; sync counts as a period boundary.
        apply    = pend_v && (boundary || sync);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            act     <= '0;
            pend    <= '0;
            pend_v  <= 1'b0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // Outputs follow the counter value of the current cycle.
            div_clk <= counting && (cnt < half);
            tick    <= counting && at_end;

            if (apply) begin
                act    <= pend;
                cnt    <= '0;
                pend_v <= 1'b0;
            end else begin
                if (sync || !counting || at_end) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // A write is only accepted while nothing is pending, so it
                // never collides with an apply.
                if (wr) begin
                    pend   <= wr_cfg;
                    pend_v <= 1'b1;
                end
            end
        end
    end

    assign pend_busy = pend_v;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable tick/clock-enable generator plus free-running power-of-two counter.
// Latency: cfg_ready combinational on cfg_chan; channel outputs registered.
// Backpressure: cfg_ready low while the addressed channel holds an unapplied write.
//
// Ports: clock, reset (async active-low), sync, cfg_valid/cfg_ready/cfg_chan/cfg_div/cfg_en
//        (config write handshake), div_clk/tick (per-channel outputs),
//        divided_clocks (bit k toggles with period 2^(k+1)).
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DIV_W  = DEF_DIV_W,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [CNT_W-1:0]  divided_clocks
);

    logic [NUM_CH-1:0] pend_busy;
    logic [NUM_CH-1:0] wr;
    logic              in_range;
    chan_cfg_t         wr_cfg;

    assign wr_cfg   = '{div: cfg_div, en: cfg_en};
    assign in_range = (int'(cfg_chan) < NUM_CH);

    // Out-of-range channels always look ready; their writes are discarded.
    always_comb begin
        cfg_ready = 1'b1;
        if (in_range) begin
            cfg_ready = !pend_busy[cfg_chan];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divided_clocks <= '0;
        end else begin
            divided_clocks <= divided_clocks + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && in_range && (cfg_chan == CH_W'(i));

        clk_div_channel u_ch (
            .clock     (clock),
            .reset     (reset),
            .sync      (sync),
            .wr        (wr[i]),
            .wr_cfg    (wr_cfg),
            .pend_busy (pend_busy[i]),
            .div_clk   (div_clk[i]),
            .tick      (tick[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 26;
    localparam int CNT_W  = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_chan;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_en;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] tick;
    logic [CNT_W-1:0]  divided_clocks;

    prog_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .sync           (sync),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_chan       (cfg_chan),
        .cfg_div        (cfg_div),
        .cfg_en         (cfg_en),
        .div_clk        (div_clk),
        .tick           (tick),
        .divided_clocks (divided_clocks)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each running channel is described by the cycle at
    // which its current period sequence started (origin) and its ratio; the
    // position within the period is (cycle - origin) mod ratio.
    longint           cyc;
    bit [CNT_W-1:0]   m_count;
    longint           m_div    [NUM_CH];
    bit               m_en     [NUM_CH];
    longint           m_origin [NUM_CH];
    bit               p_v      [NUM_CH];
    longint           p_div    [NUM_CH];
    bit               p_en     [NUM_CH];
    bit [NUM_CH-1:0]  e_div_clk;
    bit [NUM_CH-1:0]  e_tick;

    function automatic bit m_run(int i);
        return m_en[i] && (m_div[i] != 0);
    endfunction

    function automatic longint phase(int i);
        if (!m_run(i)) return 0;
        return (cyc - m_origin[i]) % m_div[i];
    endfunction

    function automatic bit exp_ready(int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !p_v[ch];
    endfunction

    function automatic void model_reset();
        cyc = 0;
        m_count = '0;
        e_div_clk = '0;
        e_tick = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = 0; m_en[i] = 0; m_origin[i] = 0;
            p_v[i] = 0; p_div[i] = 0; p_en[i] = 0;
        end
    endfunction

    // Advance one clock with the inputs currently driven, updating the model.
    task automatic step();
        bit     acc;
        int     ch;
        longint ph;
        ch  = int'(cfg_chan);
        acc = cfg_valid && exp_ready(ch);
        for (int i = 0; i < NUM_CH; i++) begin
            ph = phase(i);
            e_tick[i]    = m_run(i) && (ph == m_div[i] - 1);
            e_div_clk[i] = m_run(i) && (ph < (m_div[i] + 1) / 2);
            if (p_v[i] && (!m_run(i) || ph == m_div[i] - 1 || sync)) begin
                m_div[i] = p_div[i]; m_en[i] = p_en[i];
                m_origin[i] = cyc + 1; p_v[i] = 0;
            end else if (sync && m_en[i]) begin
                m_origin[i] = cyc + 1;
            end
        end
        if (acc && ch < NUM_CH) begin
            p_v[ch] = 1; p_div[ch] = longint'(cfg_div); p_en[ch] = cfg_en;
        end
        @(posedge clock);
        #1;
        cyc++;
        m_count++;
    endtask

    task automatic idle();
        sync = 0;
        cfg_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle(); cfg_chan = 0; cfg_div = '0; cfg_en = 0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (divided_clocks !== '0) begin n_fail++; $display("FAIL reset_count got %h exp 0", divided_clocks); end
        n_checks++; if (div_clk !== '0) begin n_fail++; $display("FAIL reset_div_clk got %b exp 0", div_clk); end
        n_checks++; if (tick !== '0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
        reset = 1;
        model_reset();
        for (int k = 0; k < 100; k++) begin
            cfg_chan = 2'($urandom_range(0, 3));
            #1;
            n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready cyc=%0d got %b exp 1", cyc, cfg_ready); end
            step();
            n_checks++; if (divided_clocks !== m_count) begin n_fail++; $display("FAIL idle_count got %0d exp %0d", divided_clocks, m_count); end
            n_checks++; if (div_clk !== 4'b0000 || tick !== 4'b0000) begin n_fail++; $display("FAIL idle_outputs cyc=%0d got div_clk=%b tick=%b exp 0/0", cyc, div_clk, tick); end
        end
    endtask

    task automatic test_div4();
        logic [12:0] seq_d, seq_t, exp_d, exp_t;
        cfg_valid = 1; cfg_chan = 0; cfg_div = 26'd4; cfg_en = 1;
        #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL div4_ready got %b exp 1", cfg_ready); end
        step();
        idle();
        for (int k = 0; k < 13; k++) begin
            step();
            seq_d[k] = div_clk[0];
            seq_t[k] = tick[0];
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL div4_model cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
        end
        exp_d = 13'b0011001100110;
        exp_t = 13'b1000100010000;
        n_checks++; if (seq_d !== exp_d) begin n_fail++; $display("FAIL div4_pattern got %b exp %b", seq_d, exp_d); end
        n_checks++; if (seq_t !== exp_t) begin n_fail++; $display("FAIL div4_ticks got %b exp %b", seq_t, exp_t); end
    endtask

    task automatic test_div5();
        logic [10:0] seq_d, seq_t, exp_d, exp_t;
        cfg_valid = 1; cfg_chan = 1; cfg_div = 26'd5; cfg_en = 1;
        #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL div5_ready got %b exp 1", cfg_ready); end
        step();
        idle();
        for (int k = 0; k < 11; k++) begin
            step();
            seq_d[k] = div_clk[1];
            seq_t[k] = tick[1];
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL div5_model cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
        end
        exp_d = 11'b00111001110;
        exp_t = 11'b10000100000;
        n_checks++; if (seq_d !== exp_d) begin n_fail++; $display("FAIL div5_pattern got %b exp %b", seq_d, exp_d); end
        n_checks++; if (seq_t !== exp_t) begin n_fail++; $display("FAIL div5_ticks got %b exp %b", seq_t, exp_t); end
    endtask

    task automatic test_update_midperiod();
        int          guard;
        int          busy;
        bit          second_done;
        logic [12:0] seq_t, exp_t;
        guard = 0;
        while (phase(0) != 1 && guard < 8) begin
            step();
            guard++;
        end
        n_checks++; if (phase(0) != 1) begin n_fail++; $display("FAIL upd_align got phase %0d exp 1", phase(0)); end
        busy = 0;
        second_done = 0;
        for (int j = 0; j < 13; j++) begin
            cfg_chan = 0; cfg_en = 1;
            if (j == 0) begin
                cfg_valid = 1; cfg_div = 26'd6;
            end else begin
                cfg_valid = !second_done; cfg_div = 26'd2;
            end
            #1;
            if (cfg_valid) begin
                n_checks++; if (cfg_ready !== exp_ready(0)) begin n_fail++; $display("FAIL upd_ready j=%0d got %b exp %b", j, cfg_ready, exp_ready(0)); end
                if (cfg_ready === 1'b0) busy++;
                if (j > 0 && exp_ready(0)) second_done = 1;
            end
            step();
            seq_t[j] = tick[0];
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL upd_model cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
        end
        idle();
        exp_t = 13'b1010100000100;
        n_checks++; if (seq_t !== exp_t) begin n_fail++; $display("FAIL upd_ticks got %b exp %b", seq_t, exp_t); end
        n_checks++; if (busy != 2) begin n_fail++; $display("FAIL upd_busy_cycles got %0d exp 2", busy); end
    endtask

    task automatic test_sync();
        int first0, first1;
        cfg_valid = 1; cfg_chan = 0; cfg_div = 26'd3; cfg_en = 1;
        step();
        cfg_chan = 1; cfg_div = 26'd7;
        step();
        idle();
        repeat ($urandom_range(3, 12)) begin
            step();
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL sync_pre cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
        end
        sync = 1;
        step();
        sync = 0;
        first0 = 0; first1 = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                n_checks++; if (div_clk[1:0] !== 2'b11) begin n_fail++; $display("FAIL sync_rise got %b exp 11", div_clk[1:0]); end
            end
            if (tick[0] && first0 == 0) first0 = k;
            if (tick[1] && first1 == 0) first1 = k;
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL sync_model cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
        end
        n_checks++; if (first0 != 3) begin n_fail++; $display("FAIL sync_tick0 got +%0d exp +3", first0); end
        n_checks++; if (first1 != 7) begin n_fail++; $display("FAIL sync_tick1 got +%0d exp +7", first1); end
    endtask

    task automatic test_sync_collision();
        sync = 1; cfg_valid = 1; cfg_chan = 0; cfg_div = 26'd5; cfg_en = 1;
        #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready got %b exp 1", cfg_ready); end
        step();
        idle();
        #1;
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL coll_still_pending got %b exp 0", cfg_ready); end
        for (int k = 0; k < 14; k++) begin
            step();
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL coll_model cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            sync      = ($urandom_range(0, 29) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_div   = ($urandom_range(0, 15) == 0) ? 26'h3FFFFFF : 26'($urandom_range(0, 9));
            cfg_en    = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (cfg_ready !== exp_ready(int'(cfg_chan))) begin n_fail++; $display("FAIL rnd_ready cyc=%0d ch=%0d got %b exp %b", cyc, cfg_chan, cfg_ready, exp_ready(int'(cfg_chan))); end
            step();
            n_checks++; if (div_clk !== e_div_clk) begin n_fail++; $display("FAIL rnd_div_clk cyc=%0d got %b exp %b", cyc, div_clk, e_div_clk); end
            n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL rnd_tick cyc=%0d got %b exp %b", cyc, tick, e_tick); end
            n_checks++; if (divided_clocks !== m_count) begin n_fail++; $display("FAIL rnd_count got %0d exp %0d", divided_clocks, m_count); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int guard;
        cfg_valid = 1; cfg_chan = 0; cfg_div = 26'd6; cfg_en = 1;
        guard = 0;
        while (!exp_ready(0) && guard < 20) begin
            step();
            guard++;
        end
        step();
        idle();
        guard = 0;
        while (phase(0) != 1 && guard < 40) begin
            step();
            guard++;
        end
        n_checks++; if (phase(0) != 1 || m_div[0] != 6) begin n_fail++; $display("FAIL rmid_setup got phase %0d div %0d exp 1/6", phase(0), m_div[0]); end
        cfg_valid = 1; cfg_chan = 0; cfg_div = 26'd2; cfg_en = 1;
        step();
        idle();
        #1;
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pending got %b exp 0", cfg_ready); end
        #1;
        reset = 0;
        #1;
        n_checks++; if (div_clk !== 4'b0000 || tick !== 4'b0000) begin n_fail++; $display("FAIL rmid_outputs got %b/%b exp 0/0", div_clk, tick); end
        n_checks++; if (divided_clocks !== '0) begin n_fail++; $display("FAIL rmid_count got %h exp 0", divided_clocks); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", cfg_ready); end
        @(posedge clock);
        #1;
        reset = 1;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++; if (div_clk !== e_div_clk || tick !== e_tick) begin n_fail++; $display("FAIL rmid_after cyc=%0d got %b/%b exp %b/%b", cyc, div_clk, tick, e_div_clk, e_tick); end
            n_checks++; if (divided_clocks !== m_count) begin n_fail++; $display("FAIL rmid_after_count got %0d exp %0d", divided_clocks, m_count); end
        end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_discarded got %b exp 1", cfg_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_div4();
        test_div5();
        test_update_midperiod();
        test_sync();
        test_sync_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
